// File: rtl/gf16_mul_sched.sv
// Shared bit-serial GF(2^4) multiplier with a two-requester round-robin front end.
// Products are formed MSB-first by Horner iteration around a single xtime stage.
module gf16_mul_sched #(
   parameter logic [3:0] POLY = 4'b0011
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [3:0] res_data,
   output logic       res_id
);

   // state | meaning
   // IDLE  | arbitrating; the granted requester sees ready and is latched
   // CALC  | four Horner steps, consuming b_q from bit 3 down to bit 0
   // DONE  | result presented on res_* until the consumer takes it
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] acc_q, acc_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [1:0] cnt_q, cnt_d;
   logic       id_q, id_d;
   logic       last_grant_q, last_grant_d;
   logic       res_valid_q, res_valid_d;
   logic [3:0] res_data_q, res_data_d;
   logic       res_id_q, res_id_d;

   logic       grant_vld;
   logic       grant_id;
   logic       hs;

   function automatic logic [3:0] xtime(input logic [3:0] v);
      return {v[2:0], 1'b0} ^ (v[3] ? POLY : 4'b0000);
   endfunction

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      grant_vld = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant_id = ~last_grant_q;
      end else begin
         grant_id = req1_valid;
      end
   end

   assign req0_ready = (state_q == IDLE) & grant_vld & ~grant_id;
   assign req1_ready = (state_q == IDLE) & grant_vld &  grant_id;
   assign hs         = (state_q == IDLE) & grant_vld;

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      a_d          = a_q;
      b_d          = b_q;
      cnt_d        = cnt_q;
      id_d         = id_q;
      last_grant_d = last_grant_q;
      res_valid_d  = res_valid_q;
      res_data_d   = res_data_q;
      res_id_d     = res_id_q;
      case (state_q)
         IDLE: begin
            if (hs) begin
               a_d          = grant_id ? req1_a : req0_a;
               b_d          = grant_id ? req1_b : req0_b;
               id_d         = grant_id;
               last_grant_d = grant_id;
               acc_d        = 4'd0;
               cnt_d        = 2'd3;
               state_d      = CALC;
            end
         end
         CALC: begin
            acc_d = xtime(acc_q) ^ (b_q[cnt_q] ? a_q : 4'd0);
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // First DONE cycle loads the result registers; release waits on res_ready.
            if (!res_valid_q) begin
               res_valid_d = 1'b1;
               res_data_d  = acc_q;
               res_id_d    = id_q;
            end else if (res_ready) begin
               res_valid_d = 1'b0;
               res_data_d  = 4'd0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
            res_data_d  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= IDLE;
         acc_q        <= 4'd0;
         a_q          <= 4'd0;
         b_q          <= 4'd0;
         cnt_q        <= 2'd0;
         id_q         <= 1'b0;
         last_grant_q <= 1'b1;
         res_valid_q  <= 1'b0;
         res_data_q   <= 4'd0;
         res_id_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         a_q          <= a_d;
         b_q          <= b_d;
         cnt_q        <= cnt_d;
         id_q         <= id_d;
         last_grant_q <= last_grant_d;
         res_valid_q  <= res_valid_d;
         res_data_q   <= res_data_d;
         res_id_q     <= res_id_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;

endmodule
